// File: rtl/counter_compare_multi_if.sv
// Control, compare and status bundle for counter_compare_multi.
// master drives the controls; slave is the counter itself.
interface counter_compare_multi_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_CMP = 3
);
  logic                     clr;
  logic                     load;
  logic [WIDTH-1:0]         load_value;
  logic                     en;
  logic                     dir;
  logic [WIDTH-1:0]         modulus;
  logic [NUM_CMP*WIDTH-1:0] cmp_value;
  logic [WIDTH-1:0]         count;
  logic [NUM_CMP-1:0]       cmp_hit;
  logic                     tc;
  logic                     running;

  modport master (
    output clr, load, load_value, en, dir,
    output modulus, cmp_value,
    input  count, cmp_hit, tc, running
  );

  modport slave (
    input  clr, load, load_value, en, dir,
    input  modulus, cmp_value,
    output count, cmp_hit, tc, running
  );
endinterface

// File: rtl/counter_compare_multi.sv
// Cascadable modulo-N up/down counter with programmable compare channels.
// tc is combinational so it can drive the next digit's en with no latency.
module counter_compare_multi #(
  parameter int WIDTH   = 4,
  parameter int NUM_CMP = 3
) (
  input logic                    clk,
  input logic                    rst,
  counter_compare_multi_if.slave bus
);

  typedef enum logic {INIT, RUN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [NUM_CMP-1:0] hit_q, hit_d;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     top_ext;
  logic [WIDTH:0]     cnt_ext;
  logic [WIDTH:0]     lv_ext;
  logic [WIDTH-1:0]   top;
  logic               up_wrap;
  logic               dn_wrap;
  logic               wrap;
  logic               run;

  // Range math is one bit wider so modulus 0 means 2**WIDTH.
  always_comb begin
    m_ext   = (bus.modulus == '0)
            ? {1'b1, {WIDTH{1'b0}}}
            : {1'b0, bus.modulus};
    top_ext = m_ext - (WIDTH+1)'(1);
    top     = top_ext[WIDTH-1:0];
    cnt_ext = {1'b0, count_q};
    lv_ext  = {1'b0, bus.load_value};
    up_wrap = cnt_ext >= top_ext;
    dn_wrap = (count_q == '0) || (cnt_ext > top_ext);
    wrap    = bus.dir ? up_wrap : dn_wrap;
  end

  assign run         = (state_q == RUN);
  assign bus.tc      = run & bus.en & ~bus.clr
                     & ~bus.load & wrap;
  assign bus.running = run;
  assign bus.count   = count_q;
  assign bus.cmp_hit = hit_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hit_d   = '0;
    unique case (state_q)
      INIT: begin
        state_d = RUN;
        count_d = '0;
      end
      RUN: begin
        if (bus.clr) begin
          count_d = '0;
        end else if (bus.load) begin
          count_d = (lv_ext > top_ext)
                  ? top : bus.load_value;
        end else if (bus.en) begin
          if (bus.dir) begin
            count_d = up_wrap
                    ? '0 : count_q + WIDTH'(1);
          end else begin
            count_d = dn_wrap
                    ? top : count_q - WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = INIT;
        count_d = '0;
      end
    endcase
    // Hits come from the next count so they line up with count.
    for (int i = 0; i < NUM_CMP; i++) begin
      hit_d[i] =
        (count_d == bus.cmp_value[i*WIDTH +: WIDTH])
        && ({1'b0, bus.cmp_value[i*WIDTH +: WIDTH]}
            < m_ext);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      count_q <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

endmodule
